// File: rtl/vga_text_renderer_pkg.sv
// Shared constants, pipeline payload type and built-in glyph table for the
// VGA character renderer.
package vga_text_renderer_pkg;

    localparam int unsigned ASCII_SIZE = 8;
    localparam int unsigned CHARS_VERT = 30;
    localparam int unsigned CHARS_HORZ = 80;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned HW      = 10;
    localparam int unsigned VW      = 10;
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned COLOR_W = 12;
    localparam int unsigned FONT_AW = 11;

    // Per-pixel control travelling alongside the glyph data through the pipeline
    typedef struct packed {
        logic       vis;
        logic       hs;
        logic       vs;
        logic       rev;
        logic       cur;
        logic [2:0] xbit;
    } pix_ctl_t;

    localparam pix_ctl_t CTL_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1,
                                      rev: 1'b0, cur: 1'b0, xbit: 3'd0};

    // Glyph row for address {code[6:0], row[3:0]}: real 'A', hollow box for
    // other printable codes, blank for controls, space and DEL.
    function automatic logic [GLYPH_W-1:0] font_row(input logic [FONT_AW-1:0] addr);
        logic [GLYPH_W-1:0] row;
        row = 8'h00;
        if (addr[10:4] == 7'h41) begin
            case (addr[3:0])
                4'd2:                      row = 8'h10;
                4'd3:                      row = 8'h38;
                4'd4:                      row = 8'h6C;
                4'd5, 4'd6:                row = 8'hC6;
                4'd7:                      row = 8'hFE;
                4'd8, 4'd9, 4'd10, 4'd11:  row = 8'hC6;
                default:                   row = 8'h00;
            endcase
        end else if (addr[10:4] > 7'h20 && addr[10:4] < 7'h7F) begin
            if (addr[3:0] == 4'd2 || addr[3:0] == 4'd13) begin
                row = 8'h7E;
            end else if (addr[3:0] > 4'd2 && addr[3:0] < 4'd13) begin
                row = 8'h42;
            end
        end
        return row;
    endfunction

endpackage

// File: rtl/vga_text_renderer_font_rom.sv
// 128 x 16 x 8 glyph ROM with one-tick registered read.
module display_font_rom
    import vga_text_renderer_pkg::*;
(
    input  logic               clk,
    input  logic               en,
    input  logic [FONT_AW-1:0] addr,
    output logic [GLYPH_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (en) begin
            data <= font_row(addr);
        end
    end

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode VGA scan-out: raster counters, 3-tick fetch/glyph/colour pipeline,
// reverse video and blinking block cursor.
module vga_text_renderer
    import vga_text_renderer_pkg::*;
#(
    parameter int unsigned PIX_DIV      = 4,
    parameter int unsigned BLINK_FRAMES = 32,
    parameter int unsigned H_VIS        = H_VISIBLE,
    parameter int unsigned H_FP         = H_FRONT,
    parameter int unsigned H_SW         = H_SYNC,
    parameter int unsigned H_BP         = H_BACK,
    parameter int unsigned V_VIS        = V_VISIBLE,
    parameter int unsigned V_FP         = V_FRONT,
    parameter int unsigned V_SW         = V_SYNC,
    parameter int unsigned V_BP         = V_BACK
) (
    input  logic                  clk,
    input  logic                  RESET_N,
    input  logic [ASCII_SIZE-1:0] DisplayBuffer [CHARS_VERT][CHARS_HORZ],
    input  logic [COLOR_W-1:0]    fg_color,
    input  logic [COLOR_W-1:0]    bg_color,
    input  logic                  cursor_en,
    input  logic [ROW_W-1:0]      cursor_row,
    input  logic [COL_W-1:0]      cursor_col,
    output logic [3:0]            VGA_R,
    output logic [3:0]            VGA_G,
    output logic [3:0]            VGA_B,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic                  frame_start,
    output logic                  in_vblank
);

    localparam int unsigned H_TOT    = H_VIS + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOT    = V_VIS + V_FP + V_SW + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SW;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SW;
    localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned BLINK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic               pix_tick_c;
    logic [HW-1:0]      h, h_nxt_c;
    logic [VW-1:0]      v, v_nxt_c;
    logic               h_last_c, v_last_c, wrap_c;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic [COL_W-1:0]      col_c;
    logic [ROW_W-1:0]      row_c;
    logic                  in_grid_c, vis_c, hs_act_c, vs_act_c, cur_c;
    logic [ASCII_SIZE-1:0] code_c;

    pix_ctl_t           ctl1, ctl2;
    logic [6:0]         code1;
    logic [3:0]         vy1;
    logic [GLYPH_W-1:0] glyph;
    logic               on_c;
    logic [COLOR_W-1:0] rgb_c;

    assign pix_tick_c = (32'(div_cnt) == PIX_DIV - 1);
    assign h_last_c   = (h == HW'(H_TOT - 1));
    assign v_last_c   = (v == VW'(V_TOT - 1));
    assign wrap_c     = pix_tick_c && h_last_c && v_last_c;

    // Pixel clock enable
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            div_cnt <= '0;
        end else if (pix_tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        h_nxt_c = h;
        v_nxt_c = v;
        if (pix_tick_c) begin
            if (h_last_c) begin
                h_nxt_c = '0;
                v_nxt_c = v_last_c ? '0 : v + 1'b1;
            end else begin
                h_nxt_c = h + 1'b1;
            end
        end
    end

    // Raster counters; in_vblank tracks the counter itself, not the pipeline
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            h           <= '0;
            v           <= '0;
            frame_start <= 1'b0;
            in_vblank   <= 1'b0;
        end else begin
            h           <= h_nxt_c;
            v           <= v_nxt_c;
            frame_start <= wrap_c;
            in_vblank   <= (32'(v_nxt_c) >= V_VIS);
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap_c) begin
            if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // S1 address decode; blanking positions can point past the grid
    always_comb begin
        col_c     = h[HW-1:3];
        row_c     = v[8:4];
        in_grid_c = (32'(col_c) < CHARS_HORZ) && (32'(row_c) < CHARS_VERT);
        code_c    = in_grid_c ? DisplayBuffer[row_c][col_c] : '0;
        vis_c     = (32'(h) < H_VIS) && (32'(v) < V_VIS);
        hs_act_c  = (32'(h) >= HS_START) && (32'(h) < HS_END);
        vs_act_c  = (32'(v) >= VS_START) && (32'(v) < VS_END);
        cur_c     = cursor_en && !blink_phase && in_grid_c &&
                    (row_c == cursor_row) && (col_c == cursor_col);
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            ctl1  <= CTL_IDLE;
            ctl2  <= CTL_IDLE;
            code1 <= '0;
            vy1   <= '0;
        end else if (pix_tick_c) begin
            ctl1  <= '{vis: vis_c, hs: ~hs_act_c, vs: ~vs_act_c,
                       rev: code_c[7], cur: cur_c, xbit: h[2:0]};
            code1 <= code_c[6:0];
            vy1   <= v[3:0];
            ctl2  <= ctl1;
        end
    end

    display_font_rom u_font (
        .clk  (clk),
        .en   (pix_tick_c),
        .addr ({code1, vy1}),
        .data (glyph)
    );

    // S3 colour select: reverse video and cursor each swap fg/bg
    always_comb begin
        on_c  = glyph[~ctl2.xbit] ^ ctl2.rev ^ ctl2.cur;
        rgb_c = '0;
        if (ctl2.vis) begin
            rgb_c = on_c ? fg_color : bg_color;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
        end else if (pix_tick_c) begin
            VGA_R  <= rgb_c[11:8];
            VGA_G  <= rgb_c[7:4];
            VGA_B  <= rgb_c[3:0];
            VGA_HS <= ctl2.hs;
            VGA_VS <= ctl2.vs;
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Scoreboard bench for vga_text_renderer on a shrunken raster; one lane at
// PIX_DIV=4 with an on-screen cursor, one at PIX_DIV=1 with an off-grid cursor.
module tb_vga_text_renderer;
    import vga_text_renderer_pkg::*;

    localparam int unsigned HV = 48, HF = 4, HSW = 8, HB = 4;
    localparam int unsigned VV = 48, VF = 2, VSW = 2, VB = 2;
    localparam int unsigned HT = HV + HF + HSW + HB;
    localparam int unsigned VT = VV + VF + VSW + VB;
    localparam int unsigned BLINK = 2;
    localparam int unsigned NL = 2;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    localparam exp_t IDLE = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  disp [CHARS_VERT][CHARS_HORZ];
    logic [11:0] fg, bg;
    logic        cur_en;
    logic [4:0]  cur_row;
    logic [7:0]  glyph_a [16];
    bit          running = 1'b0;
    bit          rst_chk = 1'b0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int lane, input int unsigned act,
                       input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s lane%0d t=%0t actual=%0h required=%0h", name, lane, $time, act, req);
        end
    endtask

    // Reference pixel from raster position, buffer contents and blink frame
    function automatic exp_t expect_px(input int unsigned x, input int unsigned y,
                                       input int unsigned frame, input logic [6:0] ccol);
        exp_t e;
        logic [7:0] code, grow;
        logic bit_v, cur, on;
        e.hs  = !(x >= HV + HF && x < HV + HF + HSW);
        e.vs  = !(y >= VV + VF && y < VV + VF + VSW);
        e.rgb = 12'h000;
        if (x < HV && y < VV) begin
            code  = disp[y / 16][x / 8];
            grow  = (code[6:0] == 7'h41) ? glyph_a[y % 16] : 8'h00;
            bit_v = grow[7 - (x % 8)];
            cur   = cur_en && ((frame / BLINK) % 2 == 0) &&
                    (y / 16 == int'(cur_row)) && (x / 8 == int'(ccol));
            on    = bit_v ^ code[7] ^ cur;
            e.rgb = on ? fg : bg;
        end
        return e;
    endfunction

    for (genvar L = 0; L < NL; L++) begin : g_lane
        localparam int unsigned DIV = (L == 0) ? 4 : 1;
        localparam logic [6:0] CCOL = (L == 0) ? 7'd5 : 7'd80;

        logic [3:0] vr, vg, vb;
        logic       vhs, vvs, fs, vbl;

        vga_text_renderer #(
            .PIX_DIV(DIV), .BLINK_FRAMES(BLINK),
            .H_VIS(HV), .H_FP(HF), .H_SW(HSW), .H_BP(HB),
            .V_VIS(VV), .V_FP(VF), .V_SW(VSW), .V_BP(VB)
        ) u_dut (
            .clk(clk), .RESET_N(rst_n), .DisplayBuffer(disp),
            .fg_color(fg), .bg_color(bg),
            .cursor_en(cur_en), .cursor_row(cur_row), .cursor_col(CCOL),
            .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .VGA_HS(vhs), .VGA_VS(vvs),
            .frame_start(fs), .in_vblank(vbl)
        );

        exp_t        q[$];
        exp_t        last_exp;
        int unsigned cyc, ph, pv, frame;
        bit          tick_seen, wrap_seen, fs_seen;

        // Stimulus side: push the expected output for the pixel the counters hold
        always @(posedge clk) begin
            tick_seen = 1'b0;
            wrap_seen = 1'b0;
            if (!running) begin
                cyc = 0; ph = 0; pv = 0; frame = 0; fs_seen = 1'b0;
                last_exp = IDLE;
                q.delete();
                q.push_back(IDLE);
                q.push_back(IDLE);
            end else begin
                cyc++;
                if (cyc % DIV == 0) begin
                    q.push_back(expect_px(ph, pv, frame, CCOL));
                    tick_seen = 1'b1;
                    if (ph == HT - 1) begin
                        ph = 0;
                        if (pv == VT - 1) begin
                            pv = 0;
                            frame++;
                            wrap_seen = 1'b1;
                        end else begin
                            pv++;
                        end
                    end else begin
                        ph++;
                    end
                end
            end
        end

        // Monitor: compare on the falling edge, away from the active edge
        always @(negedge clk) begin
            exp_t e;
            if (rst_chk && !rst_n) begin
                chk("reset_rgb", L, 32'({vr, vg, vb}), 32'h0);
                chk("reset_hs", L, 32'(vhs), 32'd1);
                chk("reset_vs", L, 32'(vvs), 32'd1);
                chk("reset_frame_start", L, 32'(fs), 32'd0);
                chk("reset_in_vblank", L, 32'(vbl), 32'd0);
            end else if (running && cyc > 0) begin
                if (tick_seen) begin
                    if (q.size() == 0) begin
                        chk("queue_underflow", L, 32'd0, 32'd1);
                    end else begin
                        e = q.pop_front();
                        last_exp = e;
                        chk("pixel_rgb", L, 32'({vr, vg, vb}), 32'(e.rgb));
                        chk("pixel_hs", L, 32'(vhs), 32'(e.hs));
                        chk("pixel_vs", L, 32'(vvs), 32'(e.vs));
                    end
                    chk("frame_start", L, 32'(fs), 32'(wrap_seen));
                    chk("in_vblank", L, 32'(vbl), 32'(pv >= VV));
                    if (wrap_seen && !fs_seen) begin
                        fs_seen = 1'b1;
                        chk("first_frame_clks", L, cyc, HT * VT * DIV);
                    end
                end else begin
                    chk("hold_rgb", L, 32'({vr, vg, vb}), 32'(last_exp.rgb));
                    chk("hold_frame_start", L, 32'(fs), 32'd0);
                end
            end
        end
    end

    initial begin
        glyph_a = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                    8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int r = 0; r < CHARS_VERT; r++) begin
            for (int c = 0; c < CHARS_HORZ; c++) begin
                disp[r][c] = 8'h20;
            end
        end
        disp[0][0] = 8'h41;
        disp[0][5] = 8'hC1;
        disp[1][3] = 8'hC1;
        disp[2][5] = 8'h41;
        fg      = 12'hE5A;
        bg      = 12'h137;
        cur_en  = 1'b1;
        cur_row = 5'd2;

        // Power-on reset
        rst_n = 1'b0;
        running = 1'b0;
        @(posedge clk);
        #1 rst_chk = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_chk = 1'b0;
        rst_n = 1'b1;
        running = 1'b1;

        // Mid-frame reset held 5 clocks
        repeat (3000) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        running = 1'b0;
        @(posedge clk);
        #1 rst_chk = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_chk = 1'b0;
        rst_n = 1'b1;
        running = 1'b1;

        // Live buffer write early in the second frame of the slow lane
        repeat (HT * VT * 4 + 200) @(posedge clk);
        @(negedge clk);
        disp[1][0] = 8'h41;

        // Run through the cursor rows of frame 2 (cursor hidden phase)
        repeat (HT * VT * 4 + 52 * HT * 4) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
